tow_game: RTL and testbench

TOW_GAME -- requirements
Module: tow_game

---
 rtl/tow_game.sv | 179 +++++++++++++++++
 tb/tb_tow_game.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tow_game.sv
// Tug-of-war reaction game: two players race to push after a dark interval.
// Latency: led_out is registered and changes on the clock edge after a push or timeout.
// Backpressure: none; a held button counts once, and pushes outside LIT are penalties or are ignored.
//
// Ports:
//   clk      - system clock, all state updates on its rising edge
//   rst      - synchronous active-low reset
//   pbl      - left player pushbutton, active-high, synchronous to clk
//   pbr      - right player pushbutton, active-high, synchronous to clk
//   led_out  - registered 7-LED bar, bit 6 leftmost, bit 0 rightmost

module tow_game #(
    parameter int DARK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    output logic [6:0] led_out
);

    // Timer counts 1..DARK_CYCLES while the bar is dark.
    localparam int TW = $clog2(DARK_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_END = TW'(DARK_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    localparam logic signed [2:0] SCORE_MIN = 3'sb101;  // -3, L3
    localparam logic signed [2:0] SCORE_MAX = 3'sb011;  // +3, R3
    localparam logic signed [2:0] SCORE_ONE = 3'sb001;

    localparam logic [6:0] LED_DARK  = 7'b0000000;
    localparam logic [6:0] LED_RESET = 7'b1010101;
    localparam logic [6:0] LED_WL    = 7'b1110000;
    localparam logic [6:0] LED_WR    = 7'b0000111;

    typedef enum logic [1:0] {
        DARK,
        LIT,
        GRACE,
        WIN
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic signed [2:0] score;
    logic              win_l;
    logic              win_r;
    logic              pbl_q;
    logic              pbr_q;

    // Rising-edge detection; the history registers reset to 1 so a button
    // already held when reset is released does not count as a push.
    logic push_l;
    logic push_r;
    logic win_pending;

    assign push_l      = pbl & ~pbl_q;
    assign push_r      = pbr & ~pbr_q;
    assign win_pending = win_l | win_r;

    // Position display: one lit LED, leftmost for L3, rightmost for R3.
    function automatic logic [6:0] pos_leds(input logic signed [2:0] s);
        logic [6:0] leds;
        case (s)
            3'sb101: leds = 7'b1000000;  // L3
            3'sb110: leds = 7'b0100000;  // L2
            3'sb111: leds = 7'b0010000;  // L1
            3'sb000: leds = 7'b0001000;  // N
            3'sb001: leds = 7'b0000100;  // R1
            3'sb010: leds = 7'b0000010;  // R2
            3'sb011: leds = 7'b0000001;  // R3
            default: leds = LED_DARK;    // -4 is never reached
        endcase
        return leds;
    endfunction

    // Saturating steps used for jump-the-gun penalties.
    function automatic logic signed [2:0] sat_inc(input logic signed [2:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_ONE;
    endfunction

    function automatic logic signed [2:0] sat_dec(input logic signed [2:0] s);
        return (s == SCORE_MIN) ? s : s - SCORE_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= DARK;
            timer   <= '0;
            score   <= '0;
            win_l   <= 1'b0;
            win_r   <= 1'b0;
            pbl_q   <= 1'b1;
            pbr_q   <= 1'b1;
            led_out <= LED_RESET;
        end else begin
            pbl_q <= pbl;
            pbr_q <= pbr;

            case (state)
                DARK: begin
                    if (push_l || push_r) begin
                        // Jump the gun: the early pusher loses a point, i.e.
                        // the rope moves toward the opponent. Left early moves
                        // right (+1), right early moves left (-1); a tie or a
                        // decided game leaves the score alone. The wait always
                        // restarts so nobody gains from guessing.
                        timer   <= TIMER_ONE;
                        led_out <= LED_DARK;
                        if (!win_pending) begin
                            if (push_l && !push_r) begin
                                score <= sat_inc(score);
                            end else if (push_r && !push_l) begin
                                score <= sat_dec(score);
                            end
                        end
                    end else if (timer == TIMER_END) begin
                        if (win_l) begin
                            state   <= WIN;
                            led_out <= LED_WL;
                        end else if (win_r) begin
                            state   <= WIN;
                            led_out <= LED_WR;
                        end else begin
                            state   <= LIT;
                            led_out <= pos_leds(score);
                        end
                    end else begin
                        timer   <= timer + TIMER_ONE;
                        led_out <= LED_DARK;
                    end
                end

                LIT: begin
                    if (push_l || push_r) begin
                        state   <= GRACE;
                        led_out <= LED_DARK;
                        if (push_l && !push_r) begin
                            // Pulling past L3 wins rather than moving further.
                            if (score == SCORE_MIN) begin
                                win_l <= 1'b1;
                            end else begin
                                score <= score - SCORE_ONE;
                            end
                        end else if (push_r && !push_l) begin
                            if (score == SCORE_MAX) begin
                                win_r <= 1'b1;
                            end else begin
                                score <= score + SCORE_ONE;
                            end
                        end
                    end else begin
                        led_out <= pos_leds(score);
                    end
                end

                GRACE: begin
                    // One blank cycle that swallows the loser's late press,
                    // then a full dark interval. The timer starts at one
                    // because this edge already begins the first dark cycle.
                    state   <= DARK;
                    timer   <= TIMER_ONE;
                    led_out <= LED_DARK;
                end

                WIN: begin
                    led_out <= win_l ? LED_WL : LED_WR;
                end

                default: begin
                    state   <= DARK;
                    timer   <= '0;
                    led_out <= LED_DARK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tow_game.sv
// Self-checking bench for tow_game with a short dark interval.
// Latency: each step applies inputs for one clock edge and samples led_out 1 ns later.
// Backpressure: not applicable; stimulus is purely directed.

module tb_tow_game;

    localparam int DC = 4;

    localparam logic [6:0] RST = 7'b1010101;
    localparam logic [6:0] DRK = 7'b0000000;
    localparam logic [6:0] L3  = 7'b1000000;
    localparam logic [6:0] L2  = 7'b0100000;
    localparam logic [6:0] L1  = 7'b0010000;
    localparam logic [6:0] N   = 7'b0001000;
    localparam logic [6:0] R1  = 7'b0000100;
    localparam logic [6:0] R2  = 7'b0000010;
    localparam logic [6:0] R3  = 7'b0000001;
    localparam logic [6:0] WL  = 7'b1110000;
    localparam logic [6:0] WR  = 7'b0000111;

    logic       clk;
    logic       rst;
    logic       pbl;
    logic       pbr;
    logic [6:0] led_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       pbl;
        logic       pbr;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    tow_game #(.DARK_CYCLES(DC)) dut (
        .clk     (clk),
        .rst     (rst),
        .pbl     (pbl),
        .pbr     (pbr),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic r, input logic l, input logic rr, input logic [6:0] e);
        vec_t v;
        v.rst = r;
        v.pbl = l;
        v.pbr = rr;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input int n, input logic [6:0] e);
        for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, e);
    endtask

    task automatic check(input string name, input logic [6:0] e);
        checks++;
        if (led_out !== e) begin
            errors++;
            $display("FAIL %s: led_out=%b expected=%b", name, led_out, e);
        end
    endtask

    task automatic step(input string name, input logic r, input logic l, input logic rr,
                        input logic [6:0] e);
        rst = r;
        pbl = l;
        pbr = rr;
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    // Push in LIT: one blank grace cycle, DC dark cycles, then the new display.
    task automatic press(input string name, input logic l, input logic rr, input logic [6:0] e);
        step({name, "_grace"}, 1'b1, l, rr, DRK);
        for (int i = 0; i < DC; i++) step({name, "_dark"}, 1'b1, 1'b0, 1'b0, DRK);
        step({name, "_show"}, 1'b1, 1'b0, 1'b0, e);
    endtask

    // pbr push in LIT, release, pbr again during DARK (penalty, timer restart).
    task automatic rejump(input string name, input logic [6:0] e);
        step({name, "_push"}, 1'b1, 1'b0, 1'b1, DRK);
        step({name, "_rel"}, 1'b1, 1'b0, 1'b0, DRK);
        step({name, "_early"}, 1'b1, 1'b0, 1'b1, DRK);
        for (int i = 0; i < DC - 1; i++) step({name, "_dark"}, 1'b1, 1'b0, 1'b0, DRK);
        step({name, "_show"}, 1'b1, 1'b0, 1'b0, e);
    endtask

    // pbr wins the race, pbl presses one cycle late and must be ignored.
    task automatic race_r(input string name, input logic [6:0] e);
        step({name, "_push"}, 1'b1, 1'b0, 1'b1, DRK);
        step({name, "_late"}, 1'b1, 1'b1, 1'b0, DRK);
        for (int i = 0; i < DC - 1; i++) step({name, "_dark"}, 1'b1, 1'b0, 1'b0, DRK);
        step({name, "_show"}, 1'b1, 1'b0, 1'b0, e);
    endtask

    task automatic reset_seq(input string name);
        step({name, "_rst0"}, 1'b0, 1'b0, 1'b0, RST);
        step({name, "_rst1"}, 1'b0, 1'b0, 1'b0, RST);
        for (int i = 0; i < DC; i++) step({name, "_dark"}, 1'b1, 1'b0, 1'b0, DRK);
        step({name, "_n"}, 1'b1, 1'b0, 1'b0, N);
    endtask

    initial begin
        logic [6:0] tgt[4];

        rst = 1'b0;
        pbl = 1'b0;
        pbr = 1'b0;

        // Reset, then four left pushes: L1, L2, L3, left win.
        add(1'b0, 1'b0, 1'b0, RST);
        add(1'b0, 1'b0, 1'b0, RST);
        add_idle(DC, DRK);
        add_idle(1, N);
        tgt[0] = L1;
        tgt[1] = L2;
        tgt[2] = L3;
        tgt[3] = WL;
        for (int k = 0; k < 4; k++) begin
            add(1'b1, 1'b1, 1'b0, DRK);
            add_idle(DC, DRK);
            add_idle(1, tgt[k]);
        end
        // Win display ignores every kind of push.
        add(1'b1, 1'b1, 1'b0, WL);
        add(1'b1, 1'b0, 1'b0, WL);
        add(1'b1, 1'b0, 1'b1, WL);
        add(1'b1, 1'b0, 1'b0, WL);
        add(1'b1, 1'b1, 1'b1, WL);
        add(1'b1, 1'b0, 1'b0, WL);
        // Reset out of WIN, then reset again in the middle of DARK.
        add(1'b0, 1'b0, 1'b0, RST);
        add_idle(2, DRK);
        add(1'b0, 1'b0, 1'b0, RST);
        add_idle(DC, DRK);
        add_idle(1, N);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i].rst, tbl[i].pbl, tbl[i].pbr, tbl[i].exp);
        end

        // Walk left to L2, then right to R3 with losing late presses, then right win.
        reset_seq("walk");
        press("walk_l1", 1'b1, 1'b0, L1);
        press("walk_l2", 1'b1, 1'b0, L2);
        race_r("race_l1", L1);
        race_r("race_n", N);
        race_r("race_r1", R1);
        race_r("race_r2", R2);
        race_r("race_r3", R3);
        press("win_r", 1'b0, 1'b1, WR);
        step("wr_hold_l", 1'b1, 1'b1, 1'b0, WR);
        step("wr_hold_idle", 1'b1, 1'b0, 1'b0, WR);
        step("wr_hold_r", 1'b1, 1'b0, 1'b1, WR);
        step("wr_hold_idle2", 1'b1, 1'b0, 1'b0, WR);
        step("wr_hold_both", 1'b1, 1'b1, 1'b1, WR);

        // N -> R1 by push, early pbr during DARK pulls back to N.
        reset_seq("pen");
        rejump("pen_n", N);
        // R2 -> R3 by push, early pbr during DARK pulls back to R2.
        press("pen_r1", 1'b0, 1'b1, R1);
        press("pen_r2", 1'b0, 1'b1, R2);
        rejump("pen_r2b", R2);

        // Held button counts exactly once.
        press("hold_r1", 1'b1, 1'b0, R1);
        press("hold_n", 1'b1, 1'b0, N);
        for (int i = 0; i < 50; i++) begin
            step($sformatf("hold[%0d]", i), 1'b1, 1'b1, 1'b0, (i < DC + 1) ? DRK : L1);
        end
        step("hold_release", 1'b1, 1'b0, 1'b0, L1);

        // Tie keeps the position.
        press("tie_l1", 1'b1, 1'b1, L1);

        // Button held through reset release is not a push.
        step("held_rst0", 1'b0, 1'b1, 1'b0, RST);
        step("held_rst1", 1'b0, 1'b1, 1'b0, RST);
        for (int i = 0; i < DC; i++) step("held_dark", 1'b1, 1'b1, 1'b0, DRK);
        step("held_n", 1'b1, 1'b1, 1'b0, N);
        step("held_rel", 1'b1, 1'b0, 1'b0, N);

        // Four early pbl penalties after reset saturate at R3 without a win.
        step("sat_rst", 1'b0, 1'b0, 1'b0, RST);
        step("sat_idle", 1'b1, 1'b0, 1'b0, DRK);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("sat_pulse[%0d]", k), 1'b1, 1'b1, 1'b0, DRK);
            if (k < 3) step($sformatf("sat_gap[%0d]", k), 1'b1, 1'b0, 1'b0, DRK);
        end
        for (int i = 0; i < DC - 1; i++) step("sat_dark", 1'b1, 1'b0, 1'b0, DRK);
        step("sat_r3", 1'b1, 1'b0, 1'b0, R3);

        // Win at R3, then an early pbr during DARK must not cancel it.
        rejump("win_pending", WR);
        step("final_rst", 1'b0, 1'b0, 1'b0, RST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
